// File: rtl/b8_fetch_pkg.sv
// Shared fetch-path definitions: responder FSM states, the NOP word returned for
// misaligned fetches, and the default request-queue depth.
package b8_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  localparam int unsigned INST_WIDTH         = 32;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;
  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

  // A fetch address is word-aligned only when its two low bits are zero.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/resp_req_fifo.sv
// Request queue for the fetch responder: circular buffer with push, pop and a
// single-edge flush that empties it; pointers wrap modulo Depth.
module resp_req_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CntW'(Depth));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign rdata_o = r_mem[r_rd_ptr];

  assign w_push = push_i & ~full_o & ~flush_i;
  assign w_pop  = pop_i & ~empty_o & ~flush_i;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/inst_bus_responder.sv
// Instruction-fetch bus responder: queues fetch addresses, keeps one memory read in
// flight, returns words in order and drops anything overtaken by a jump flush.
// Optional build macro INST_RESP_ALIGN_CHECK_EN answers misaligned fetches with a NOP.
module inst_bus_responder
  import b8_fetch_pkg::*;
#(
  parameter int unsigned FifoDepth = DEFAULT_FIFO_DEPTH,
  parameter int unsigned AddrWidth = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  request_i,
  input  logic [AddrWidth-1:0]  addr_i,
  input  logic                  flush_i,
  output logic                  ready_o,
  output logic                  dataOk_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [AddrWidth-1:0]  instAddr_o,
  output logic                  mem_en_o,
  output logic [AddrWidth-1:0]  mem_addr_o,
  input  logic [INST_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_rvalid_i
);

  localparam int unsigned CntW = $clog2(FifoDepth) + 1;

  fetch_state_e          r_state;
  logic [AddrWidth-1:0]  r_issue_addr;
  logic [AddrWidth-1:0]  r_inst_addr;
  logic [INST_WIDTH-1:0] r_inst;
  logic                  r_data_ok;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_resp;
  logic [INST_WIDTH-1:0] w_resp_data;
  logic [AddrWidth-1:0]  w_head;
  logic [CntW-1:0]       w_count;

  resp_req_fifo #(
    .Depth (FifoDepth),
    .Width (AddrWidth)
  ) u_req_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (flush_i),
    .wdata_i (addr_i),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign ready_o = (w_count != CntW'(FifoDepth));
  assign w_push  = request_i & ~w_full & ~flush_i;
  assign w_pop   = (r_state == ST_IDLE) & ~w_empty & ~flush_i;

`ifdef INST_RESP_ALIGN_CHECK_EN
  // A misaligned head is popped like a real fetch but answered locally with a NOP.
  logic r_local;
  logic w_misaligned;

  assign w_misaligned = is_misaligned(w_head[1:0]);
  assign w_issue      = w_pop & ~w_misaligned;
  assign w_resp       = r_local | mem_rvalid_i;
  assign w_resp_data  = r_local ? NOP_INST : mem_rdata_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_local <= 1'b0;
    end else if (w_pop) begin
      r_local <= w_misaligned;
    end
  end
`else
  assign w_issue     = w_pop;
  assign w_resp      = mem_rvalid_i;
  assign w_resp_data = mem_rdata_i;
`endif

  assign mem_en_o   = w_issue;
  assign mem_addr_o = w_head;

  // Fetch sequencer: issue from the queue head, then wait for (or discard) the reply.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_issue_addr <= '0;
      r_data_ok    <= 1'b0;
      r_inst       <= '0;
      r_inst_addr  <= '0;
    end else begin
      r_data_ok <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state      <= ST_WAIT;
            r_issue_addr <= w_head;
          end
        end
        ST_WAIT: begin
          if (w_resp) begin
            r_state <= ST_IDLE;
            if (!flush_i) begin
              r_data_ok   <= 1'b1;
              r_inst      <= w_resp_data;
              r_inst_addr <= r_issue_addr;
            end
          end else if (flush_i) begin
            r_state <= ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          // The outstanding reply still has to drain before a new read may issue.
          if (mem_rvalid_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dataOk_o   = r_data_ok;
  assign inst_o     = r_inst;
  assign instAddr_o = r_inst_addr;

endmodule
